// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the four-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NREQ = 4;
  localparam int SEL_W = 2;
  localparam int WIDTH_DEF = 32;
  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Circular priority pick among four requests, starting just after the last winner.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    // Offset 4 wraps to last itself, so a lone repeat requester still wins.
    for (int i = 1; i <= NREQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select and registering the result for a valid/ready consumer.
// Optional lock-to-winner priority is built when MUX4_ARB_LOCK_EN is defined.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [3:0]       Req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [3:0]       Lock,
`endif
  output logic [3:0]       Grant,
  output logic [1:0]       Selector,
  input  logic [WIDTH-1:0] Mux_Result,
  output logic [WIDTH-1:0] Result,
  output logic [1:0]       Result_Src,
  output logic             Result_Valid,
  input  logic             Result_Ready,
  output logic             Dbg_State
);

  // Handshake: the consumer takes Result at a rising edge where Result_Valid
  // and Result_Ready are both high; requester i transfers at an edge where
  // Req[i] and Grant[i] are both high.

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       rr_winner, winner;
  logic             any_req, cap;

`ifdef MUX4_ARB_LOCK_EN
  logic             locked_q, locked_d;
  logic [1:0]       lock_idx_q, lock_idx_d;
`endif

  rr_pick4 u_pick (
    .req    (Req),
    .last   (last_q),
    .winner (rr_winner),
    .any    (any_req)
  );

  assign cap = any_req & ((state_q == ST_EMPTY) | Result_Ready);

`ifdef MUX4_ARB_LOCK_EN
  assign winner = (locked_q && Req[lock_idx_q]) ? lock_idx_q : rr_winner;
`else
  assign winner = rr_winner;
`endif

  // sel_q mirrors last_q except straight out of reset, where the idle select is 0.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    src_d    = src_q;
    last_d   = last_q;
    sel_d    = sel_q;
    Grant    = 4'b0000;
    Selector = sel_q;
`ifdef MUX4_ARB_LOCK_EN
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
`endif
    if (cap) begin
      Grant    = 4'b0001 << winner;
      Selector = winner;
      result_d = Mux_Result;
      src_d    = winner;
      state_d  = ST_FULL;
      last_d   = winner;
`ifdef MUX4_ARB_LOCK_EN
      if (Lock[winner]) begin
        locked_d   = 1'b1;
        lock_idx_d = winner;
        last_d     = last_q;
      end else begin
        locked_d = 1'b0;
      end
`endif
      sel_d = last_d;
    end else if ((state_q == ST_FULL) && Result_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_EMPTY;
      result_q <= '0;
      src_q    <= '0;
      last_q   <= LAST_RST;
      sel_q    <= '0;
`ifdef MUX4_ARB_LOCK_EN
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      src_q    <= src_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
`ifdef MUX4_ARB_LOCK_EN
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign Result       = result_q;
  assign Result_Src   = src_q;
  assign Result_Valid = (state_q == ST_FULL);
  assign Dbg_State    = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, reset/lock sequences, randomized run vs. model.
module tb_mux4_rr_arbiter;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [3:0]   Req;
  logic [3:0]   Grant;
  logic [1:0]   Selector;
  logic [W-1:0] Mux_Result;
  logic [W-1:0] Result;
  logic [1:0]   Result_Src;
  logic         Result_Valid;
  logic         Result_Ready;
  logic         Dbg_State;
`ifdef MUX4_ARB_LOCK_EN
  logic [3:0]   Lock = 4'b0000;
`endif

  logic [W-1:0] r [4];
  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  always #5 Clk = ~Clk;

  // Behavioural mux4to1 feeding the arbiter.
  assign Mux_Result = r[Selector];

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req          (Req),
`ifdef MUX4_ARB_LOCK_EN
    .Lock         (Lock),
`endif
    .Grant        (Grant),
    .Selector     (Selector),
    .Mux_Result   (Mux_Result),
    .Result       (Result),
    .Result_Src   (Result_Src),
    .Result_Valid (Result_Valid),
    .Result_Ready (Result_Ready),
    .Dbg_State    (Dbg_State)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain ints, circular search from the previous winner.
  int           m_last;
  int           m_sel;
  bit           m_valid;
  logic [W-1:0] m_result;
  int           m_src;
  bit           m_locked;
  int           m_lidx;

  function automatic int pick_next(input logic [3:0] rq, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (rq[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 3; m_sel = 0; m_valid = 0; m_result = '0; m_src = 0;
    m_locked = 0; m_lidx = 0;
  endtask

  // Driver: called just after a rising edge with inputs already set.
  task automatic cycle();
    bit cap;
    int win;
    cap = (Req != 4'b0000) && (!m_valid || Result_Ready);
    win = pick_next(Req, m_last);
`ifdef MUX4_ARB_LOCK_EN
    if (m_locked && Req[m_lidx]) win = m_lidx;
`endif
    @(negedge Clk);
    check("grant", W'(Grant), cap ? W'(1 << win) : W'(0));
    check("selector", W'(Selector), cap ? W'(win) : W'(m_sel));
    @(posedge Clk);
    if (cap) begin
      m_result = r[win];
      m_src    = win;
      m_valid  = 1;
`ifdef MUX4_ARB_LOCK_EN
      if (Lock[win]) begin
        m_locked = 1;
        m_lidx   = win;
      end else begin
        m_locked = 0;
        m_last   = win;
      end
`else
      m_last = win;
`endif
      m_sel = m_last;
    end else if (m_valid && Result_Ready) begin
      m_valid = 0;
    end
    #1;
    check("result", Result, m_result);
    check("result_src", W'(Result_Src), W'(m_src));
    check("result_valid", W'(Result_Valid), W'(m_valid));
    check("dbg_state", W'(Dbg_State), W'(m_valid));
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Req = 4'b0000;
    Result_Ready = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_result", Result, '0);
    check("rst_src", W'(Result_Src), '0);
    check("rst_valid", W'(Result_Valid), '0);
    check("rst_grant", W'(Grant), '0);
    check("rst_selector", W'(Selector), '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]   req;
    logic         rdy;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [W-1:0] res;
    logic [1:0]   src;
    logic         vld;
  } vec_t;

  vec_t tbl[19];
  logic [W-1:0] exp_q[$];

  localparam logic [W-1:0] VA = 32'hDEADBEEF;
  localparam logic [W-1:0] VB = 32'hCAFEBABE;
  localparam logic [W-1:0] VC = 32'h0BADF00D;
  localparam logic [W-1:0] VD = 32'h01234567;

  initial begin
    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, VA, 2'd0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, VB, 2'd1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, VC, 2'd2, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, VD, 2'd3, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, VA, 2'd0, 1'b1};
    tbl[5]  = '{4'b0110, 1'b1, 4'b0010, 2'd1, VB, 2'd1, 1'b1};
    for (int i = 6; i <= 10; i++) tbl[i] = '{4'b0110, 1'b0, 4'b0000, 2'd1, VB, 2'd1, 1'b1};
    tbl[11] = '{4'b0110, 1'b1, 4'b0100, 2'd2, VC, 2'd2, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 2'd2, VC, 2'd2, 1'b0};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 2'd2, VC, 2'd2, 1'b0};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 2'd2, VC, 2'd2, 1'b0};
    tbl[15] = '{4'b0001, 1'b0, 4'b0001, 2'd0, VA, 2'd0, 1'b1};
    tbl[16] = '{4'b1000, 1'b0, 4'b0000, 2'd0, VA, 2'd0, 1'b1};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 2'd0, VA, 2'd0, 1'b0};
    tbl[18] = '{4'b1001, 1'b1, 4'b1000, 2'd3, VD, 2'd3, 1'b1};

    r[0] = VA; r[1] = VB; r[2] = VC; r[3] = VD;
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      Req = tbl[i].req;
      Result_Ready = tbl[i].rdy;
      @(negedge Clk);
      check($sformatf("tbl%0d_grant", i), W'(Grant), W'(tbl[i].grant));
      check($sformatf("tbl%0d_sel", i), W'(Selector), W'(tbl[i].sel));
      @(posedge Clk);
      #1;
      check($sformatf("tbl%0d_result", i), Result, tbl[i].res);
      check($sformatf("tbl%0d_src", i), W'(Result_Src), W'(tbl[i].src));
      check($sformatf("tbl%0d_valid", i), W'(Result_Valid), W'(tbl[i].vld));
    end

    // Asynchronous reset while a word is pending.
    Req = 4'b0000;
    Result_Ready = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst_valid", W'(Result_Valid), '0);
    check("async_rst_result", Result, '0);
    check("async_rst_grant", W'(Grant), '0);
    model_reset();
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    Req = 4'b1001;
    Result_Ready = 1'b1;
    cycle();
    check("post_rst_src_first", W'(Result_Src), W'(0));
    cycle();
    check("post_rst_src_second", W'(Result_Src), W'(3));

`ifdef MUX4_ARB_LOCK_EN
    // Lock on requester 2 holds priority until Lock is cleared.
    do_reset();
    exp_q = '{W'(0), W'(1), W'(2), W'(2), W'(2), W'(2), W'(3), W'(0), W'(1)};
    Req = 4'b1111;
    Result_Ready = 1'b1;
    Lock = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) Lock = 4'b0000;
      cycle();
      check($sformatf("lock_src%0d", k), W'(Result_Src), exp_q.pop_front());
    end
    Lock = 4'b0000;
`endif

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 4; j++) r[j] = $urandom;
      Req = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      Result_Ready = ($urandom_range(0, 3) != 0);
`ifdef MUX4_ARB_LOCK_EN
      Lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
